training_sample_server: RTL and testbench

- Responder side of the neuron controller's request/dataReady handshake.
- Stores a training set of (x1, x2, t) samples written by the testbench or host before training.
- Serves one sample per request, in order, and flags the last sample of each epoch (eof), which drives the neuron's flagEOF input.
- Pointer wraps automatically for the next epoch; a rewind input realigns it when the neuron restarts training.

---
 rtl/training_sample_server_if.sv | 11 +
 rtl/training_sample_server.sv | 99 +++++++++
 tb/tb_training_sample_server.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/training_sample_server_if.sv
// training_sample_server_if: request/dataReady handshake and served-sample bus between neuron controller and sample server
interface training_sample_server_if #(parameter int DATA_W = 8);
    logic              request;
    logic              data_ready;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] t;
    logic              eof;
    modport master (output request, input data_ready, x1, x2, t, eof);
    modport slave (input request, output data_ready, x1, x2, t, eof);
endinterface

// File: rtl/training_sample_server.sv
// training_sample_server: stores (x1, x2, t) samples and serves one per request in order, flagging the last of each epoch
module training_sample_server #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int EPOCH_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                wr_en_i,
    input  logic [DATA_W-1:0]   wr_x1_i,
    input  logic [DATA_W-1:0]   wr_x2_i,
    input  logic [DATA_W-1:0]   wr_t_i,
    input  logic                rewind_i,
    training_sample_server_if.slave bus,
    output logic                busy_o,
    output logic                full_o,
    output logic                err_empty_o,
    output logic [ADDR_W:0]     sample_count_o,
    output logic [EPOCH_W-1:0]  epoch_count_o
);
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, WAIT_LOW} state_t;
    state_t                  state_q;
    logic [ADDR_W-1:0]       ptr_q;
    logic [ADDR_W:0]         cnt_q;
    logic [EPOCH_W-1:0]      epoch_q;
    logic                    dr_q, eof_q, err_q;
    logic [DATA_W-1:0]       x1_q, x2_q, t_q;
    logic [3*DATA_W-1:0]     mem_q [DEPTH];
    logic                    wr_ok;
    assign full_o         = cnt_q == (ADDR_W+1)'(DEPTH);
    assign busy_o         = state_q != IDLE;
    assign err_empty_o    = err_q;
    assign sample_count_o = cnt_q;
    assign epoch_count_o  = epoch_q;
    assign bus.data_ready = dr_q;
    assign bus.x1         = x1_q;
    assign bus.x2         = x2_q;
    assign bus.t          = t_q;
    assign bus.eof        = eof_q;
    // Appends only while the handshake is quiet so a fetch never races a write
    assign wr_ok = wr_en_i && !clear_i && state_q == IDLE && !bus.request && !full_o;
    always_ff @(posedge clk)
        if (wr_ok) mem_q[cnt_q[ADDR_W-1:0]] <= {wr_x1_i, wr_x2_i, wr_t_i};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            epoch_q <= '0;
            dr_q    <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            t_q     <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            epoch_q <= '0;
            dr_q    <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            t_q     <= '0;
        end else begin
            dr_q <= 1'b0;
            if (wr_ok) cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: if (bus.request) state_q <= FETCH;
                FETCH: begin
                    state_q <= PRESENT;
                    if (cnt_q == '0) begin
                        {x1_q, x2_q, t_q} <= '0;
                        eof_q             <= 1'b1;
                        err_q             <= 1'b1;
                    end else begin
                        {x1_q, x2_q, t_q} <= mem_q[ptr_q];
                        eof_q             <= {1'b0, ptr_q} == cnt_q - 1'b1;
                    end
                end
                PRESENT: begin
                    state_q <= WAIT_LOW;
                    dr_q    <= 1'b1;
                    // eof_q records whether the sample just served closed the epoch
                    if (cnt_q != '0) begin
                        ptr_q   <= eof_q ? '0 : ptr_q + 1'b1;
                        epoch_q <= eof_q ? epoch_q + 1'b1 : epoch_q;
                    end
                end
                WAIT_LOW: if (!bus.request) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (rewind_i) ptr_q <= '0;
        end
endmodule

// File: tb/tb_training_sample_server.sv
// tb_training_sample_server: directed self-checking bench for training_sample_server
module tb_training_sample_server;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0, wr_en = 1'b0, rewind = 1'b0;
    logic [7:0] wr_x1 = '0, wr_x2 = '0, wr_t = '0;
    logic       busy, full, err_empty;
    logic [6:0] sample_count;
    logic [7:0] epoch_count;
    int         n_chk = 0, n_fail = 0;
    training_sample_server_if #(.DATA_W(8)) sif ();
    training_sample_server #(.DATA_W(8), .DEPTH(64), .ADDR_W(6), .EPOCH_W(8)) dut (
        .clk(clk), .rst(rst), .clear_i(clear), .wr_en_i(wr_en),
        .wr_x1_i(wr_x1), .wr_x2_i(wr_x2), .wr_t_i(wr_t), .rewind_i(rewind),
        .bus(sif), .busy_o(busy), .full_o(full), .err_empty_o(err_empty),
        .sample_count_o(sample_count), .epoch_count_o(epoch_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        wr_en = 1'b1;
        wr_x1 = a;
        wr_x2 = b;
        wr_t  = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask
    task automatic load3();
        wr(8'd1, 8'd2, 8'd1);
        wr(8'd3, 8'hFC, 8'hFF);
        wr(8'd5, 8'd6, 8'd1);
    endtask
    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask
    task automatic serve(input string tag, input logic [7:0] ex1, input logic [7:0] ex2,
                         input logic [7:0] et, input logic eeof);
        int lat;
        lat = 0;
        sif.request = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!sif.data_ready && lat < 20);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_x1"}, sif.x1, ex1);
        check({tag, "_x2"}, sif.x2, ex2);
        check({tag, "_t"}, sif.t, et);
        check({tag, "_eof"}, sif.eof, eeof);
        sif.request = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, sif.data_ready, 0);
        check({tag, "_eofhold"}, sif.eof, eeof);
    endtask
    initial begin
        int pulses;
        sif.request = 1'b0;
        @(negedge clk);
        check("rst_dr", sif.data_ready, 0);
        check("rst_x1", sif.x1, 0);
        check("rst_eof", sif.eof, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", sample_count, 0);
        check("rst_epoch", epoch_count, 0);
        check("rst_err", err_empty, 0);
        check("rst_full", full, 0);
        rst = 1'b0;
        @(negedge clk);
        load3();
        check("load_cnt", sample_count, 3);
        serve("s0", 8'd1, 8'd2, 8'd1, 1'b0);
        check("ep_a", epoch_count, 0);
        serve("s1", 8'd3, 8'hFC, 8'hFF, 1'b0);
        serve("s2", 8'd5, 8'd6, 8'd1, 1'b1);
        check("ep_b", epoch_count, 1);
        serve("s0b", 8'd1, 8'd2, 8'd1, 1'b0);
        check("ep_c", epoch_count, 1);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        sif.request = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sif.data_ready) pulses++;
            check("hold_x1", sif.x1, 1);
        end
        check("hold_pulses", pulses, 1);
        sif.request = 1'b0;
        repeat (2) @(negedge clk);
        pulse_clear();
        check("clr_cnt", sample_count, 0);
        check("clr_epoch", epoch_count, 0);
        load3();
        serve("rw0", 8'd1, 8'd2, 8'd1, 1'b0);
        serve("rw1", 8'd3, 8'hFC, 8'hFF, 1'b0);
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        serve("rw2", 8'd1, 8'd2, 8'd1, 1'b0);
        check("rw_epoch", epoch_count, 0);
        sif.request = 1'b1;
        @(negedge clk);
        check("busy_fetch", busy, 1);
        wr_en = 1'b1;
        wr_x1 = 8'd9;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        sif.request = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_wr_drop", sample_count, 3);
        pulse_clear();
        for (int i = 0; i < 65; i++) wr(8'(i), 8'(i), 8'(i));
        check("full_cnt", sample_count, 64);
        check("full_flag", full, 1);
        pulse_clear();
        serve("empty", 8'd0, 8'd0, 8'd0, 1'b1);
        check("empty_err", err_empty, 1);
        check("empty_epoch", epoch_count, 0);
        pulse_clear();
        check("clr_err", err_empty, 0);
        check("clr_cnt2", sample_count, 0);
        load3();
        serve("pre_rst", 8'd1, 8'd2, 8'd1, 1'b0);
        sif.request = 1'b1;
        @(negedge clk);
        check("rst_fetch_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_dr", sif.data_ready, 0);
        check("arst_x1", sif.x1, 0);
        check("arst_eof", sif.eof, 0);
        check("arst_cnt", sample_count, 0);
        check("arst_epoch", epoch_count, 0);
        sif.request = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (sif.data_ready) pulses++;
        end
        check("arst_nopulse", pulses, 0);
        rst = 1'b0;
        @(negedge clk);
        load3();
        serve("post_rst", 8'd1, 8'd2, 8'd1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
